// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types and widths for the data-memory responder.
//   state_e : responder FSM states (IDLE, WAIT, RESP)
//   WORD_W  : data word width
//   CNT_W   : wait-state down-counter width (covers WAIT_STATES up to 15)
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// dmem_array: synchronous single-port RAM, DEPTH x WORD_W.
//   clk, rst_n : clock, async active-low reset (read register only; contents are not reset)
//   en_i       : access strobe, asserted only on the commit edge
//   we_i       : 1 = write wdata_i, 0 = read into rdata_o
//   idx_i      : word index
//   wdata_i    : write data
//   rdata_o    : registered read data; returns to 0 on any edge without a read
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en_i,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] idx_i,
    input  logic [WORD_W-1:0]        wdata_i,
    output logic [WORD_W-1:0]        rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];
    logic [WORD_W-1:0] rdata_q;

    // Storage array, no reset.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Read register doubles as the response data: zero unless a load just committed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= (en_i && !we_i) ? mem_q[idx_i] : '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word-addressed load/store responder with configurable wait states.
//   clk, reset : clock, async active-low reset
//   req_valid / req_ready : request handshake (ready only in IDLE)
//   req_we, req_addr, req_wdata : request fields, latched at acceptance
//   rsp_valid : one-cycle response pulse
//   rsp_rdata : load data, 0 outside a load response
//   rsp_err   : misaligned-access flag
// Optional macro DMEM_MISALIGN_ERR_EN: misaligned requests flag rsp_err, suppress
// the store and return zero load data; when undefined the low address bits are ignored.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH       = 64,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [WORD_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WORD_W-1:0]  wdata_q, wdata_d;
    logic               mis_q, mis_d;
    logic               req_ready_q, rsp_valid_q, rsp_err_q;
    logic               commit_c;
    logic               mis_c;
    logic               unused_addr;

`ifdef DMEM_MISALIGN_ERR_EN
    assign mis_c = (req_addr[1:0] != 2'b00);
`else
    assign mis_c = 1'b0;
`endif

    // Address bits outside the word index do not affect the access.
    assign unused_addr = ^{req_addr[WORD_W-1:IDX_W+2], req_addr[1:0]};

    // Next-state, request latch and commit strobe.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        we_d     = we_q;
        idx_d    = idx_q;
        wdata_d  = wdata_q;
        mis_d    = mis_q;
        commit_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    idx_d   = req_addr[IDX_W+1:2];
                    wdata_d = req_wdata;
                    mis_d   = mis_c;
                    cnt_d   = WAIT_LOAD;
                    if (WAIT_STATES == 0) begin
                        state_d  = RESP;
                        commit_c = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d  = RESP;
                    commit_c = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, request latch and response registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            mis_q       <= 1'b0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            mis_q       <= mis_d;
            req_ready_q <= (state_d == IDLE);
            rsp_valid_q <= commit_c;
            rsp_err_q   <= commit_c & mis_d;
        end
    end

    // The _d request fields equal the live inputs when committing on the acceptance edge.
    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst_n   (reset),
        .en_i    (commit_c & ~mis_d),
        .we_i    (we_d),
        .idx_i   (idx_d),
        .wdata_i (wdata_d),
        .rdata_o (rsp_rdata)
    );

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: two responders (WAIT_STATES 0 and 2, DEPTH 64) driven with
// directed and random accesses and checked against a word-array reference model.
module tb_dmem_responder;

    localparam int unsigned DEPTH = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic        rsp_valid [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference memory contents for each instance.
    logic [31:0] mem_m [2][DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut_w0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_responder #(.DEPTH(DEPTH), .WAIT_STATES(2)) u_dut_w2 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_idle(input int d, input string tag);
        check({tag, "_ready"}, 32'(req_ready[d]), 32'd1);
        check({tag, "_valid"}, 32'(rsp_valid[d]), 32'd0);
        check({tag, "_rdata"}, rsp_rdata[d], 32'd0);
        check({tag, "_err"},   32'(rsp_err[d]),   32'd0);
    endtask

    // One complete access; expected response comes from the reference model.
    // After acceptance the inputs are scrambled to a store of all-ones to 0x20 and
    // req_valid stays high until the responder is back in IDLE; none of that may land.
    task automatic access(input int d, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata);
        int          lat;
        int          ws;
        int          idx;
        logic        mis;
        logic [31:0] exp_rd;
        ws  = (d == 0) ? 0 : 2;
        idx = int'(addr[7:2]);
`ifdef DMEM_MISALIGN_ERR_EN
        mis = (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        exp_rd = (we || mis) ? 32'h0 : mem_m[d][idx];
        if (we && !mis) mem_m[d][idx] = wdata;

        check("ready_before", 32'(req_ready[d]), 32'd1);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        @(posedge clk); #1;
        req_we[d]    = 1'b1;
        req_addr[d]  = 32'h20;
        req_wdata[d] = 32'hFFFF_FFFF;
        lat = 0;
        while (rsp_valid[d] !== 1'b1 && lat < 20) begin
            check("ready_busy", 32'(req_ready[d]), 32'd0);
            check("rdata_quiet", rsp_rdata[d], 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'(ws));
        check("ready_in_resp", 32'(req_ready[d]), 32'd0);
        check("rsp_rdata", rsp_rdata[d], exp_rd);
        check("rsp_err", 32'(rsp_err[d]), 32'(mis));
        rdata = rsp_rdata[d];
        @(posedge clk); #1;
        req_valid[d] = 1'b0;
        check_idle(d, "after_rsp");
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] prior;
        logic [31:0] a;
        logic [31:0] wd;
        logic        w;

        reset = 1'b0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = 32'h0;
            req_wdata[d] = 32'h0;
        end

        // Reset held for three cycles.
        repeat (3) begin
            @(posedge clk); #1;
            check_idle(0, "rst_w0");
            check_idle(1, "rst_w2");
        end
        @(negedge clk);
        reset = 1'b1;

        // Preload every word; word 2 (0x8) is zero for the aborted-store check.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                wd = (i == 2) ? 32'h0 : $urandom();
                access(d, 1'b1, 32'(i * 4), wd, rd);
            end
        end

        // Store then load, two wait states.
        access(1, 1'b1, 32'h10, 32'hDEAD_BEEF, rd);
        check("st_deadbeef_rdata", rd, 32'h0);
        access(1, 1'b0, 32'h10, 32'h0, rd);
        check("ld_deadbeef", rd, 32'hDEAD_BEEF);

        // Zero wait states, address wrap to word 0.
        access(0, 1'b1, 32'h100, 32'h1234_5678, rd);
        access(0, 1'b0, 32'h0, 32'h0, rd);
        check("ld_wrap", rd, 32'h1234_5678);

        // Word 0x20 must be untouched by the post-acceptance scramble.
        access(0, 1'b0, 32'h20, 32'h0, rd);
        access(1, 1'b0, 32'h20, 32'h0, rd);
        check("ld_0x20_not_ones", 32'(rd == 32'hFFFF_FFFF), 32'd0);

        // Reset pulsed while a store sits in WAIT.
        check("abort_ready", 32'(req_ready[1]), 32'd1);
        req_valid[1] = 1'b1;
        req_we[1]    = 1'b1;
        req_addr[1]  = 32'h8;
        req_wdata[1] = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        req_valid[1] = 1'b0;
        check("abort_in_wait", 32'(req_ready[1]), 32'd0);
        reset = 1'b0;
        #1;
        check("abort_async_ready", 32'(req_ready[1]), 32'd1);
        check("abort_async_valid", 32'(rsp_valid[1]), 32'd0);
        repeat (3) begin
            @(posedge clk); #1;
            check("abort_no_rsp", 32'(rsp_valid[1]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        access(1, 1'b0, 32'h8, 32'h0, rd);
        check("ld_after_abort", rd, 32'h0);

        // Misaligned store.
        access(1, 1'b0, 32'h4, 32'h0, prior);
        access(1, 1'b1, 32'h6, 32'h1111_1111, rd);
        access(1, 1'b0, 32'h4, 32'h0, rd);
`ifdef DMEM_MISALIGN_ERR_EN
        check("ld_after_misaligned", rd, prior);
`else
        check("ld_after_misaligned", rd, 32'h1111_1111);
`endif

        // Random mix on both instances, back-to-back.
        for (int n = 0; n < 120; n++) begin
            a = $urandom();
            if (($urandom() % 4) != 0) a = a & 32'hFFFF_FFFC;
            w = 1'($urandom() % 2);
            access(n % 2, w, a, $urandom(), rd);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder serving the processor datapath's load/store port. It accepts one request per handshake and holds the request through a configurable number of wait states. It then performs the read or write against local storage and returns a single-cycle response. It sits between the datapath's ALUResult/WriteData/ReadData path and the memory array, so the core can be verified against a memory with realistic latency.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit words; power of two, ≥ 2
- WAIT_STATES, 2, extra cycles between acceptance and response; 0–15

Ports:
- clk  input  1  single clock, rising-edge
- reset  input  1  asynchronous, active-low reset; asserted when 0
- req_valid  input  1  request present
- req_ready  output  1  responder can accept; high only in IDLE
- req_we  input  1  1 = store, 0 = load
- req_addr  input  32  byte address (ALUResult)
- req_wdata  input  32  store data (WriteData)
- rsp_valid  output  1  one-cycle response pulse
- rsp_rdata  output  32  load data (ReadData); valid only while rsp_valid
- rsp_err  output  1  misaligned-access flag, qualified by rsp_valid

## Operation
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready at a clock edge, req_we, req_addr and req_wdata are latched; the requester may change them afterwards.
  - Next state is WAIT if WAIT_STATES > 0, otherwise RESP.
- WAIT:
  - Down-counter loaded with WAIT_STATES−1 at acceptance.
  - Stays in WAIT while count ≠ 0, decrementing each cycle.
  - At count = 0, goes to RESP on the next edge.
- Commit edge: the edge that enters RESP.
  - Store: word written.
  - Load: word read into rsp_rdata.
- RESP:
  - rsp_valid = 1 for exactly one cycle, with no back-pressure.
  - Then returns to IDLE unconditionally.
- Word index = req_addr[log2(DEPTH)+1:2]. Upper bits are ignored, so the address wraps modulo DEPTH*4.
- Store response: rsp_rdata = 0, rsp_err = 0 (unless the access is misaligned, see Configuration).
- Outside RESP: rsp_rdata and rsp_err are held at 0.
- req_valid while not IDLE is ignored; the requester must hold it until accepted.

## Timing
- Reset values: state IDLE, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
- Memory contents are not reset.
- Acceptance at edge E0 → rsp_valid high during the cycle after edge E0+WAIT_STATES.
  - WAIT_STATES = 0: rsp_valid in the cycle immediately after E0.
- req_ready rises again after edge E0+WAIT_STATES+1. Peak throughput is one access per WAIT_STATES+2 cycles.
- Load issued after a store to the same word returns the new data: the store commits before the next acceptance.
- Reset asserted mid-operation:
  - Returns to IDLE immediately (asynchronous).
  - A store whose commit edge has not occurred is dropped.
  - rsp_valid is forced to 0 and no response is issued for the aborted request.
- Reset deassertion: the first acceptance is possible at the first rising edge with reset = 1.

## Configuration
- Macro: DMEM_MISALIGN_ERR_EN.
- Defined:
  - A request with req_addr[1:0] ≠ 0 produces rsp_err = 1 in RESP.
  - A misaligned store is suppressed, with no array write.
  - A misaligned load returns rsp_rdata = 0.
  - Latency is unchanged.
- Undefined:
  - req_addr[1:0] is ignored and the access proceeds at the truncated word index.
  - rsp_err is tied to 0.

## Structure
- Package dmem_pkg:
  - State enum typedef (IDLE, WAIT, RESP).
  - Constant WORD_W = 32.
  - Wait-counter width constant (4 bits).
- Sub-module dmem_array:
  - Synchronous single-port RAM, DEPTH × WORD_W.
  - Inputs: we, word index, wdata. Output: registered rdata.
  - Driven only on the commit edge.
- dmem_responder holds the FSM, request latch, wait counter and response registers.

## Test plan
- Reset then idle, reset held low 3 cycles → req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 throughout.
- WAIT_STATES = 2: store 0xDEADBEEF to 0x10, then load 0x10.
  - Store: rsp_valid exactly 2 cycles after acceptance with rsp_rdata = 0.
  - Load: rsp_rdata = 0xDEADBEEF.
  - req_ready low for 3 cycles after each acceptance.
- WAIT_STATES = 0, DEPTH = 64: store 0x12345678 to 0x100 (wraps to word 0), then load 0x0.
  - Load returns 0x12345678.
  - rsp_valid one cycle after each acceptance.
- Request inputs changed on the cycle after acceptance to addr 0x20, wdata 0xFFFFFFFF.
  - Original latched request is committed.
  - Word 0x20 remains unchanged.
- Reset pulsed during WAIT of a store of 0xA5A5A5A5 to 0x8.
  - No rsp_valid is issued.
  - After reset, a load of 0x8 does not return 0xA5A5A5A5 (word was preloaded 0x0 by the bench).
- DMEM_MISALIGN_ERR_EN defined: store 0x11111111 to 0x6 → rsp_err = 1. A later load of 0x4 returns its prior value. Without the macro: rsp_err = 0 and word 0x4 = 0x11111111.
